// File: rtl/can_irq_pkg.sv
// Shared definitions for the CAN interrupt status path: source bit map and irq FSM encoding.
package can_irq_pkg;

   localparam int unsigned NUM_SRC_DFLT = 12;

   localparam int unsigned IDX_ARBLST = 0;
   localparam int unsigned IDX_TXOK   = 1;
   localparam int unsigned IDX_TXFLL  = 2;
   localparam int unsigned IDX_TXBFLL = 3;
   localparam int unsigned IDX_RXOK   = 4;
   localparam int unsigned IDX_RXUFLW = 5;
   localparam int unsigned IDX_RXOFLW = 6;
   localparam int unsigned IDX_RXNEMP = 7;
   localparam int unsigned IDX_ERROR  = 8;
   localparam int unsigned IDX_BSOFF  = 9;
   localparam int unsigned IDX_SLP    = 10;
   localparam int unsigned IDX_WKUP   = 11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } irq_state_e;

endpackage

// File: rtl/can_irq_prio_enc.sv
// Lowest-index-wins priority encoder producing the pending-source index (0 when nothing pending).
module can_irq_prio_enc #(
   parameter int unsigned NUM_SRC = 12
) (
   input  logic [NUM_SRC-1:0] req_i,
   output logic [3:0]         id_o
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      id_o = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (req_i[i]) id_o = 4'(i);
      end
   end

endmodule

// File: rtl/can_irq_latch.sv
// CAN interrupt status latch: sticky status/overrun bits, W1C clear, enable gating, registered irq + index.
// Optional irq holdoff FSM is built when CAN_IRQ_HOLDOFF_EN is defined.
module can_irq_latch
   import can_irq_pkg::*;
#(
   parameter int unsigned NUM_SRC     = NUM_SRC_DFLT,
   parameter int unsigned HOLDOFF_CYC = 64
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [NUM_SRC-1:0] evt_in,
   input  logic [31:0]        DEMUX2interrupt_en,
   input  logic [31:0]        DEMUX2interrupt_clr,
   input  logic               clr_wr,
   output logic [31:0]        isr2MUX,
   output logic [31:0]        ovr2MUX,
   output logic               irq,
   output logic [3:0]         irq_id
);

   logic [NUM_SRC-1:0] evt_q;
   logic [NUM_SRC-1:0] isr_q, isr_d;
   logic [NUM_SRC-1:0] ovr_q, ovr_d;
   logic [NUM_SRC-1:0] rise, clr_hit, pending;
   logic               irq_q, irq_d;
   logic               unused_hi;

   assign unused_hi = ^{DEMUX2interrupt_en[31:NUM_SRC], DEMUX2interrupt_clr[31:NUM_SRC]};

   // A new rise always beats a clear in the same cycle, so no event is ever lost to a racing W1C.
   always_comb begin
      rise    = evt_in & ~evt_q;
      clr_hit = {NUM_SRC{clr_wr}} & DEMUX2interrupt_clr[NUM_SRC-1:0];
      isr_d   = rise | (isr_q & ~clr_hit);
      ovr_d   = (rise & isr_q) | (ovr_q & ~clr_hit);
      pending = isr_q & DEMUX2interrupt_en[NUM_SRC-1:0];
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         evt_q <= '0;
         isr_q <= '0;
         ovr_q <= '0;
         irq_q <= 1'b0;
      end else begin
         evt_q <= evt_in;
         isr_q <= isr_d;
         ovr_q <= ovr_d;
         irq_q <= irq_d;
      end
   end

`ifdef CAN_IRQ_HOLDOFF_EN
   localparam int unsigned CNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

   irq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      irq_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (|pending) begin
               state_d = ST_ASSERT;
               irq_d   = 1'b1;
            end
         end
         ST_ASSERT: begin
            if (|pending) begin
               irq_d = 1'b1;
            end else begin
               state_d = ST_HOLDOFF;
               cnt_d   = CNT_W'(HOLDOFF_CYC - 1);
            end
         end
         ST_HOLDOFF: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end
`else
   assign irq_d = |pending;
`endif

   can_irq_prio_enc #(
      .NUM_SRC (NUM_SRC)
   ) u_prio_enc (
      .req_i (pending),
      .id_o  (irq_id)
   );

   assign isr2MUX = {{(32 - NUM_SRC){1'b0}}, isr_q};
   assign ovr2MUX = {{(32 - NUM_SRC){1'b0}}, ovr_q};
   assign irq     = irq_q;

endmodule

// File: tb/tb_can_irq_latch.sv
// Directed table-driven bench for can_irq_latch plus hand-written multi-cycle sequences.
module tb_can_irq_latch;
   import can_irq_pkg::*;

   localparam int unsigned N   = 12;
   localparam int unsigned HOC = 8;
`ifdef CAN_IRQ_HOLDOFF_EN
   localparam int SETTLE  = HOC + 1;
   localparam int EXP_LOW = 1 + HOC;
`else
   localparam int SETTLE  = 0;
   localparam int EXP_LOW = 1;
`endif

   typedef struct {
      logic [31:0] evt;
      logic [31:0] en;
      logic [31:0] clr;
      logic        wr;
      logic [31:0] e_isr;
      logic [31:0] e_ovr;
      logic        e_irq;
      logic [3:0]  e_id;
      logic        settle;
   } vec_t;

   logic           sys_clk = 1'b0;
   logic           sys_rst_n = 1'b0;
   logic [N-1:0]   evt_in = '0;
   logic [31:0]    en = '0;
   logic [31:0]    clr = '0;
   logic           clr_wr = 1'b0;
   logic [31:0]    isr2MUX, ovr2MUX;
   logic           irq;
   logic [3:0]     irq_id;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   can_irq_latch #(.NUM_SRC(N), .HOLDOFF_CYC(HOC)) dut (
      .sys_clk             (sys_clk),
      .sys_rst_n           (sys_rst_n),
      .evt_in              (evt_in),
      .DEMUX2interrupt_en  (en),
      .DEMUX2interrupt_clr (clr),
      .clr_wr              (clr_wr),
      .isr2MUX             (isr2MUX),
      .ovr2MUX             (ovr2MUX),
      .irq                 (irq),
      .irq_id              (irq_id)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic [31:0] e, input logic [31:0] n, input logic [31:0] c, input logic w);
      evt_in = e[N-1:0];
      en     = n;
      clr    = c;
      clr_wr = w;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic add(input logic [31:0] e, input logic [31:0] n, input logic [31:0] c, input logic w,
                      input logic [31:0] ei, input logic [31:0] eo, input logic eq, input logic [3:0] ed,
                      input logic st);
      vec_t v;
      v.evt = e; v.en = n; v.clr = c; v.wr = w;
      v.e_isr = ei; v.e_ovr = eo; v.e_irq = eq; v.e_id = ed; v.settle = st;
      vecs.push_back(v);
   endtask

   initial begin
      int low;
      bit seen;

      // evt      en        clr          wr  isr       ovr     irq  id  settle
      add(32'h000, 32'h010, 32'h000,     0, 32'h000, 32'h00, 0, 0, 0); // 0 idle
      add(32'h010, 32'h010, 32'h000,     0, 32'h010, 32'h00, 0, 4, 0); // 1 RXOK pulse
      add(32'h000, 32'h010, 32'h000,     0, 32'h010, 32'h00, 1, 4, 0); // 2 irq follows
      add(32'h000, 32'h010, 32'h001,     1, 32'h010, 32'h00, 1, 4, 0); // 3 clear other bit
      add(32'h000, 32'h010, 32'h010,     1, 32'h000, 32'h00, 1, 0, 0); // 4 clear RXOK
      add(32'h000, 32'h010, 32'h000,     0, 32'h000, 32'h00, 0, 0, 1); // 5 irq drops
      add(32'h002, 32'h000, 32'h000,     0, 32'h002, 32'h00, 0, 0, 0); // 6 TXOK disabled
      add(32'h000, 32'h000, 32'h000,     0, 32'h002, 32'h00, 0, 0, 0); // 7 stays low
      add(32'h000, 32'h002, 32'h000,     0, 32'h002, 32'h00, 1, 1, 0); // 8 enable
      add(32'h000, 32'h002, 32'h002,     1, 32'h000, 32'h00, 1, 0, 0); // 9 clear
      add(32'h000, 32'h002, 32'h000,     0, 32'h000, 32'h00, 0, 0, 1); // 10
      add(32'h010, 32'h010, 32'h000,     0, 32'h010, 32'h00, 0, 4, 0); // 11 RXOK
      add(32'h000, 32'h010, 32'h000,     0, 32'h010, 32'h00, 1, 4, 0); // 12
      add(32'h010, 32'h010, 32'h010,     1, 32'h010, 32'h10, 1, 4, 0); // 13 rise vs clear
      add(32'h000, 32'h010, 32'h010,     1, 32'h000, 32'h00, 1, 0, 0); // 14 clear both
      add(32'h000, 32'h010, 32'h000,     0, 32'h000, 32'h00, 0, 0, 1); // 15
      add(32'h0A0, 32'hFFF, 32'h000,     0, 32'h0A0, 32'h00, 0, 5, 0); // 16 two sources
      add(32'h080, 32'hFFF, 32'h000,     0, 32'h0A0, 32'h00, 1, 5, 0); // 17 held, no rise
      add(32'h880, 32'hFFF, 32'h000,     0, 32'h8A0, 32'h00, 1, 5, 0); // 18 WKUP
      add(32'h000, 32'hFFF, 32'hFFFFF020,1, 32'h880, 32'h00, 1, 7, 0); // 19 upper clr ignored
      add(32'h080, 32'hFFF, 32'h000,     0, 32'h880, 32'h80, 1, 7, 0); // 20 overrun
      add(32'h080, 32'hFFF, 32'h880,     1, 32'h000, 32'h00, 1, 0, 0); // 21 clear all
      add(32'h000, 32'hFFF, 32'h000,     0, 32'h000, 32'h00, 0, 0, 1); // 22
      add(32'h001, 32'hFFFFF800, 32'h000,0, 32'h001, 32'h00, 0, 0, 0); // 23 ARBLST disabled
      add(32'h000, 32'hFFFFF800, 32'h000,0, 32'h001, 32'h00, 0, 0, 0); // 24 upper en ignored
      add(32'h000, 32'h000, 32'h001,     1, 32'h000, 32'h00, 0, 0, 0); // 25

      // Reset state
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst isr", isr2MUX, 32'h0);
      check("rst ovr", ovr2MUX, 32'h0);
      check("rst irq", {31'b0, irq}, 32'h0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].evt, vecs[i].en, vecs[i].clr, vecs[i].wr);
         check($sformatf("v%0d isr", i), isr2MUX, vecs[i].e_isr);
         check($sformatf("v%0d ovr", i), ovr2MUX, vecs[i].e_ovr);
         check($sformatf("v%0d irq", i), {31'b0, vecs[i].e_irq ^ 1'b0} ^ {31'b0, irq} ^ {31'b0, vecs[i].e_irq} , {31'b0, vecs[i].e_irq});
         if (vecs[i].e_irq) check($sformatf("v%0d id", i), {28'b0, irq_id}, {28'b0, vecs[i].e_id});
         else if (vecs[i].e_id != 0) check($sformatf("v%0d id", i), {28'b0, irq_id}, {28'b0, vecs[i].e_id});
         if (vecs[i].settle)
            for (int k = 0; k < SETTLE; k++) step(vecs[i].evt, vecs[i].en, 32'h0, 1'b0);
      end

      // BSOFF held high: one rise only, cleared while high stays clear
      step(32'h200, 32'h200, 32'h0, 1'b0);
      check("bsoff set", isr2MUX, 32'h200);
      for (int k = 0; k < 4; k++) begin
         step(32'h200, 32'h200, 32'h0, 1'b0);
         check($sformatf("bsoff hold%0d", k), isr2MUX, 32'h200);
         check($sformatf("bsoff ovr%0d", k), ovr2MUX, 32'h0);
      end
      step(32'h200, 32'h200, 32'h200, 1'b1);
      check("bsoff clr", isr2MUX, 32'h0);
      for (int k = 0; k < 14; k++) begin
         step(32'h200, 32'h200, 32'h0, 1'b0);
         check($sformatf("bsoff stay%0d", k), isr2MUX, 32'h0);
      end
      step(32'h000, 32'h200, 32'h0, 1'b0);
      check("bsoff low", isr2MUX, 32'h0);
      step(32'h200, 32'h200, 32'h0, 1'b0);
      check("bsoff rerise", isr2MUX, 32'h200);

      // Asynchronous reset mid-operation, then a line high across release
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("midrst isr", isr2MUX, 32'h0);
      check("midrst irq", {31'b0, irq}, 32'h0);
      evt_in = 12'h001;
      en     = 32'h001;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      step(32'h001, 32'h001, 32'h0, 1'b0);
      check("release rise", isr2MUX, 32'h001);
      step(32'h001, 32'h001, 32'h0, 1'b0);
      check("release irq", {31'b0, irq}, 32'h1);
      check("release ovr", ovr2MUX, 32'h0);
      step(32'h000, 32'h000, 32'h001, 1'b1);
      check("release clr", isr2MUX, 32'h0);
      for (int k = 0; k < HOC + 2; k++) step(32'h0, 32'h0, 32'h0, 1'b0);

      // Clear then re-fire next cycle: irq low for 1 cycle, or 1+HOLDOFF_CYC with holdoff
      step(32'h010, 32'h010, 32'h0, 1'b0);
      step(32'h000, 32'h010, 32'h0, 1'b0);
      check("ho irq up", {31'b0, irq}, 32'h1);
      step(32'h000, 32'h010, 32'h010, 1'b1);
      check("ho clr irq", {31'b0, irq}, 32'h1);
      check("ho clr isr", isr2MUX, 32'h0);
      step(32'h010, 32'h010, 32'h0, 1'b0);
      check("ho refire isr", isr2MUX, 32'h010);
      check("ho refire irq", {31'b0, irq}, 32'h0);
      low  = 1;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step(32'h010, 32'h010, 32'h0, 1'b0);
         if (irq) seen = 1'b1;
         else     low++;
      end
      check("ho irq returns", {31'b0, seen}, 32'h1);
      check("ho low cycles", low, EXP_LOW);
      check("ho id", {28'b0, irq_id}, {28'b0, 4'(IDX_RXOK)});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
